// File: rtl/mem_stage_skid_reg_pkg.sv
// Shared ISA constants, default field widths and the exception-source selector
// for the MEM->WB stage register.
package mem_stage_skid_reg_pkg;

    localparam int PC_W_DEF       = 30;
    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CTRL_OP_W_DEF  = 2;
    localparam int EXP_W_DEF      = 3;
    localparam int CNT_W_DEF      = 16;

    localparam logic [CTRL_OP_W_DEF-1:0] CTRL_OP_NOP = '0;

    typedef enum logic [EXP_W_DEF-1:0] {
        ISA_EXP_NO_EXP     = 3'd0,
        ISA_EXP_MISS_ALIGN = 3'd1,
        ISA_EXP_BUS_ERR    = 3'd2
    } isa_exp_e;

    typedef enum logic [1:0] {
        EXP_SRC_PASS,
        EXP_SRC_MISS_ALIGN,
        EXP_SRC_BUS_ERR
    } exp_src_e;

    // An exception raised by an earlier stage always wins over MEM faults.
    function automatic exp_src_e exp_select(input logic has_in_exp,
                                            input logic miss_align,
                                            input logic bus_err);
        exp_src_e src;
        src = EXP_SRC_PASS;
        if (!has_in_exp) begin
            if (miss_align)   src = EXP_SRC_MISS_ALIGN;
            else if (bus_err) src = EXP_SRC_BUS_ERR;
        end
        return src;
    endfunction

endpackage

// File: rtl/mem_stage_skid_reg_if.sv
// Upstream/downstream handshake bundle of the MEM->WB stage register.
// master = pipeline environment, slave = the stage register itself.
interface mem_stage_skid_reg_if
    import mem_stage_skid_reg_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CTRL_OP_W  = CTRL_OP_W_DEF,
    parameter int EXP_W      = EXP_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
);
    logic                  flush;

    logic                  in_valid;
    logic                  in_ready;
    logic [PC_W-1:0]       in_pc;
    logic                  in_br_flag;
    logic [CTRL_OP_W-1:0]  in_ctrl_op;
    logic [REG_ADDR_W-1:0] in_dst_addr;
    logic                  in_gpr_we_;
    logic [EXP_W-1:0]      in_exp_code;
    logic [DATA_W-1:0]     in_data;
    logic                  miss_align;
    logic                  bus_err;

    logic                  out_valid;
    logic                  out_ready;
    logic [PC_W-1:0]       out_pc;
    logic                  out_br_flag;
    logic [CTRL_OP_W-1:0]  out_ctrl_op;
    logic [REG_ADDR_W-1:0] out_dst_addr;
    logic                  out_gpr_we_;
    logic [EXP_W-1:0]      out_exp_code;
    logic [DATA_W-1:0]     out_data;

    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output flush, in_valid, in_pc, in_br_flag, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code, in_data, miss_align, bus_err, out_ready,
        input  in_ready, out_valid, out_pc, out_br_flag, out_ctrl_op, out_dst_addr,
               out_gpr_we_, out_exp_code, out_data, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_pc, in_br_flag, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code, in_data, miss_align, bus_err, out_ready,
        output in_ready, out_valid, out_pc, out_br_flag, out_ctrl_op, out_dst_addr,
               out_gpr_we_, out_exp_code, out_data, stall_cnt
    );

endinterface

// File: rtl/mem_stage_skid_reg_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered upstream ready and flush.
module pipe_skid_buf #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_main_v;
    logic             r_skid_v;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_d;
    logic [WIDTH-1:0] r_skid_d;

    logic             w_accept;
    logic             w_main_free;

    assign w_accept    = i_valid & r_in_ready;
    assign w_main_free = ~r_main_v | i_ready;

    // Upstream ready tracks ~skid_valid, so an accept can never coincide with a
    // full skid; when main frees up, the skid entry moves forward first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            r_main_d   <= RESET_VAL;
            r_skid_d   <= RESET_VAL;
        end else if (i_flush) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            r_main_d   <= RESET_VAL;
            r_skid_d   <= RESET_VAL;
        end else if (w_main_free) begin
            if (r_skid_v) begin
                r_main_v   <= 1'b1;
                r_main_d   <= r_skid_d;
                r_skid_v   <= 1'b0;
                r_in_ready <= 1'b1;
            end else begin
                r_main_v   <= w_accept;
                r_in_ready <= 1'b1;
                if (w_accept) begin
                    r_main_d <= i_data;
                end
            end
        end else if (w_accept) begin
            r_skid_v   <= 1'b1;
            r_skid_d   <= i_data;
            r_in_ready <= 1'b0;
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_main_v;
    assign o_data  = r_main_d;

endmodule

// File: rtl/mem_stage_skid_reg.sv
// MEM->WB pipeline register: MEM exception injection ahead of a 2-entry skid
// buffer, plus a saturating back-pressure cycle counter.
module mem_stage_skid_reg
    import mem_stage_skid_reg_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CTRL_OP_W  = CTRL_OP_W_DEF,
    parameter int EXP_W      = EXP_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mem_stage_skid_reg_if.slave bus
);
    localparam int PAY_W = PC_W + 1 + CTRL_OP_W + REG_ADDR_W + 1 + EXP_W + DATA_W;

    localparam logic [PAY_W-1:0] RST_PAY = {
        PC_W'(0), 1'b0, CTRL_OP_W'(CTRL_OP_NOP), REG_ADDR_W'(0),
        1'b1, EXP_W'(ISA_EXP_NO_EXP), DATA_W'(0)
    };

    exp_src_e              w_exp_src;
    logic [CTRL_OP_W-1:0]  w_ctrl_op;
    logic [REG_ADDR_W-1:0] w_dst_addr;
    logic                  w_gpr_we_;
    logic [EXP_W-1:0]      w_exp_code;
    logic [DATA_W-1:0]     w_data;
    logic [PAY_W-1:0]      w_in_pay;
    logic [PAY_W-1:0]      w_out_pay;
    logic                  w_out_valid;
    logic                  w_in_ready;
    logic [CNT_W-1:0]      r_stall_cnt;

    // An injected exception kills the write-back side effects but keeps pc/br_flag.
    always_comb begin
        w_exp_src  = exp_select(bus.in_exp_code != EXP_W'(ISA_EXP_NO_EXP),
                                bus.miss_align, bus.bus_err);
        w_ctrl_op  = bus.in_ctrl_op;
        w_dst_addr = bus.in_dst_addr;
        w_gpr_we_  = bus.in_gpr_we_;
        w_exp_code = bus.in_exp_code;
        w_data     = bus.in_data;
        if (w_exp_src != EXP_SRC_PASS) begin
            w_ctrl_op  = CTRL_OP_W'(CTRL_OP_NOP);
            w_dst_addr = '0;
            w_gpr_we_  = 1'b1;
            w_data     = '0;
            w_exp_code = (w_exp_src == EXP_SRC_MISS_ALIGN) ? EXP_W'(ISA_EXP_MISS_ALIGN)
                                                           : EXP_W'(ISA_EXP_BUS_ERR);
        end
    end

    assign w_in_pay = {bus.in_pc, bus.in_br_flag, w_ctrl_op, w_dst_addr,
                       w_gpr_we_, w_exp_code, w_data};

    pipe_skid_buf #(
        .WIDTH     (PAY_W),
        .RESET_VAL (RST_PAY)
    ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_flush (bus.flush),
        .i_valid (bus.in_valid),
        .o_ready (w_in_ready),
        .i_data  (w_in_pay),
        .o_valid (w_out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_pay)
    );

    assign {bus.out_pc, bus.out_br_flag, bus.out_ctrl_op, bus.out_dst_addr,
            bus.out_gpr_we_, bus.out_exp_code, bus.out_data} = w_out_pay;
    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage_skid_reg.sv
// Bench for mem_stage_skid_reg: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_stage_skid_reg;
    import mem_stage_skid_reg_pkg::*;

    typedef struct packed {
        logic [29:0] pc;
        logic        br;
        logic [1:0]  op;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] data;
    } pay_t;

    localparam pay_t RST_PAY = '{pc: 30'd0, br: 1'b0, op: 2'd0, dst: 5'd0,
                                 we_: 1'b1, exp: 3'd0, data: 32'd0};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_stage_skid_reg_if #(.CNT_W(16)) ifc ();
    mem_stage_skid_reg_if #(.CNT_W(4))  is2 ();

    mem_stage_skid_reg #(.CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    mem_stage_skid_reg #(.CNT_W(4)) u_dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (is2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries held by the stage form a FIFO of at most two.
    pay_t        m_q[$];
    pay_t        m_hold = RST_PAY;
    logic        m_rdy  = 1'b1;
    logic [15:0] m_cnt  = 16'd0;

    function automatic pay_t captured();
        pay_t p;
        p.pc   = ifc.in_pc;
        p.br   = ifc.in_br_flag;
        p.op   = ifc.in_ctrl_op;
        p.dst  = ifc.in_dst_addr;
        p.we_  = ifc.in_gpr_we_;
        p.exp  = ifc.in_exp_code;
        p.data = ifc.in_data;
        if (ifc.in_exp_code == ISA_EXP_NO_EXP && (ifc.miss_align || ifc.bus_err)) begin
            p.exp  = ifc.miss_align ? ISA_EXP_MISS_ALIGN : ISA_EXP_BUS_ERR;
            p.op   = CTRL_OP_NOP;
            p.dst  = 5'd0;
            p.we_  = 1'b1;
            p.data = 32'd0;
        end
        return p;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic acc;
        if (reset) begin
            m_q.delete();
            m_hold = RST_PAY;
            m_rdy  = 1'b1;
            m_cnt  = 16'd0;
        end else begin
            if (m_q.size() > 0 && !ifc.out_ready && m_cnt != 16'hFFFF) m_cnt++;
            if (ifc.flush) begin
                m_q.delete();
                m_hold = RST_PAY;
                m_rdy  = 1'b1;
            end else begin
                acc = ifc.in_valid && m_rdy;
                if (m_q.size() > 0 && ifc.out_ready) void'(m_q.pop_front());
                if (acc) m_q.push_back(captured());
                m_rdy = (m_q.size() < 2);
                if (m_q.size() > 0) m_hold = m_q[0];
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_out_valid", 64'(ifc.out_valid), 64'(m_q.size() > 0));
            chk("m_in_ready",  64'(ifc.in_ready),  64'(m_rdy));
            chk("m_stall_cnt", 64'(ifc.stall_cnt), 64'(m_cnt));
            chk("m_out_pc",    64'(ifc.out_pc),    64'(m_hold.pc));
            chk("m_out_data",  64'(ifc.out_data),  64'(m_hold.data));
            chk("m_out_ctl",
                64'({ifc.out_br_flag, ifc.out_ctrl_op, ifc.out_dst_addr, ifc.out_gpr_we_, ifc.out_exp_code}),
                64'({m_hold.br, m_hold.op, m_hold.dst, m_hold.we_, m_hold.exp}));
        end
    end

    task automatic cyc(input logic v, input logic [29:0] pc, input logic ordy,
                       input logic ma = 1'b0, input logic be = 1'b0,
                       input logic [2:0] ex = 3'd0, input logic fl = 1'b0);
        ifc.in_valid    = v;
        ifc.in_pc       = pc;
        ifc.in_br_flag  = pc[0];
        ifc.in_ctrl_op  = 2'b10;
        ifc.in_dst_addr = pc[4:0];
        ifc.in_gpr_we_  = 1'b0;
        ifc.in_exp_code = ex;
        ifc.in_data     = {2'b00, pc} ^ 32'hA5A5_0000;
        ifc.miss_align  = ma;
        ifc.bus_err     = be;
        ifc.out_ready   = ordy;
        ifc.flush       = fl;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 64'(ifc.out_valid),    64'(0));
        chk({tag, "_in_ready"},  64'(ifc.in_ready),     64'(1));
        chk({tag, "_stall_cnt"}, 64'(ifc.stall_cnt),    64'(0));
        chk({tag, "_out_pc"},    64'(ifc.out_pc),       64'(0));
        chk({tag, "_br_flag"},   64'(ifc.out_br_flag),  64'(0));
        chk({tag, "_ctrl_op"},   64'(ifc.out_ctrl_op),  64'(0));
        chk({tag, "_dst_addr"},  64'(ifc.out_dst_addr), 64'(0));
        chk({tag, "_gpr_we_"},   64'(ifc.out_gpr_we_),  64'(1));
        chk({tag, "_exp_code"},  64'(ifc.out_exp_code), 64'(0));
        chk({tag, "_out_data"},  64'(ifc.out_data),     64'(0));
    endtask

    initial begin
        ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.in_pc = '0; ifc.in_br_flag = 1'b0;
        ifc.in_ctrl_op = '0; ifc.in_dst_addr = '0; ifc.in_gpr_we_ = 1'b1; ifc.in_exp_code = '0;
        ifc.in_data = '0; ifc.miss_align = 1'b0; ifc.bus_err = 1'b0; ifc.out_ready = 1'b1;
        is2.flush = 1'b0; is2.in_valid = 1'b0; is2.in_pc = '0; is2.in_br_flag = 1'b0;
        is2.in_ctrl_op = '0; is2.in_dst_addr = '0; is2.in_gpr_we_ = 1'b1; is2.in_exp_code = '0;
        is2.in_data = '0; is2.miss_align = 1'b0; is2.bus_err = 1'b0; is2.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Streaming: one entry per cycle, one cycle latency, no bubbles
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 30'(32'h10 + i), 1'b1);
            chk("stream_pc",    64'(ifc.out_pc),    64'(32'h10 + i));
            chk("stream_valid", 64'(ifc.out_valid), 64'(1));
        end
        cyc(1'b0, 30'h0, 1'b1);
        chk("stream_drained", 64'(ifc.out_valid), 64'(0));

        // Back-pressure: two stalled cycles fill the skid entry
        cyc(1'b1, 30'h20, 1'b1);
        cyc(1'b1, 30'h21, 1'b0);
        chk("bp_ready_low1", 64'(ifc.in_ready), 64'(0));
        cyc(1'b1, 30'h22, 1'b0);
        chk("bp_ready_low2", 64'(ifc.in_ready),  64'(0));
        chk("bp_stall_cnt",  64'(ifc.stall_cnt), 64'(2));
        chk("bp_head_pc",    64'(ifc.out_pc),    64'(32'h20));
        cyc(1'b1, 30'h22, 1'b1);
        chk("bp_pc_21",  64'(ifc.out_pc),   64'(32'h21));
        chk("bp_ready",  64'(ifc.in_ready), 64'(1));
        cyc(1'b1, 30'h22, 1'b1);
        chk("bp_pc_22",  64'(ifc.out_pc),   64'(32'h22));
        cyc(1'b0, 30'h0, 1'b1);
        chk("bp_empty",  64'(ifc.out_valid), 64'(0));

        // Exception injection
        cyc(1'b1, 30'h30, 1'b1, 1'b1, 1'b1);
        chk("exc_ma_code", 64'(ifc.out_exp_code), 64'(ISA_EXP_MISS_ALIGN));
        chk("exc_ma_we_",  64'(ifc.out_gpr_we_),  64'(1));
        chk("exc_ma_dst",  64'(ifc.out_dst_addr), 64'(0));
        chk("exc_ma_op",   64'(ifc.out_ctrl_op),  64'(0));
        chk("exc_ma_data", 64'(ifc.out_data),     64'(0));
        chk("exc_ma_pc",   64'(ifc.out_pc),       64'(32'h30));
        cyc(1'b1, 30'h31, 1'b1, 1'b0, 1'b1);
        chk("exc_be_code", 64'(ifc.out_exp_code), 64'(ISA_EXP_BUS_ERR));
        chk("exc_be_br",   64'(ifc.out_br_flag),  64'(1));
        chk("exc_be_data", 64'(ifc.out_data),     64'(0));
        cyc(1'b1, 30'h32, 1'b1, 1'b1, 1'b0, 3'd5);
        chk("exc_up_code", 64'(ifc.out_exp_code), 64'(5));
        chk("exc_up_dst",  64'(ifc.out_dst_addr), 64'(5'h12));
        chk("exc_up_we_",  64'(ifc.out_gpr_we_),  64'(0));
        chk("exc_up_op",   64'(ifc.out_ctrl_op),  64'(2));
        chk("exc_up_data", 64'(ifc.out_data),     64'(32'hA5A5_0032));
        cyc(1'b0, 30'h0, 1'b1);

        // Flush with both entries full and a pending input
        cyc(1'b1, 30'h40, 1'b0);
        cyc(1'b1, 30'h41, 1'b0);
        chk("fl_full_ready", 64'(ifc.in_ready), 64'(0));
        cyc(1'b1, 30'h42, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        chk("fl_valid", 64'(ifc.out_valid),   64'(0));
        chk("fl_ready", 64'(ifc.in_ready),    64'(1));
        chk("fl_pc",    64'(ifc.out_pc),      64'(0));
        chk("fl_we_",   64'(ifc.out_gpr_we_), 64'(1));
        cyc(1'b0, 30'h0, 1'b1);
        chk("fl_no_ghost", 64'(ifc.out_valid), 64'(0));
        // Flush overriding a same-cycle accept
        cyc(1'b1, 30'h50, 1'b0);
        cyc(1'b1, 30'h51, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        chk("fl2_valid", 64'(ifc.out_valid), 64'(0));
        chk("fl2_ready", 64'(ifc.in_ready),  64'(1));
        cyc(1'b0, 30'h0, 1'b1);
        cyc(1'b0, 30'h0, 1'b1);
        chk("fl2_dropped",   64'(ifc.out_valid), 64'(0));
        chk("fl2_stall_cnt", 64'(ifc.stall_cnt), 64'(5));

        // Asynchronous reset mid-stream, sampled before any clock edge
        cyc(1'b1, 30'h60, 1'b0);
        cyc(1'b1, 30'h61, 1'b0);
        #2 reset = 1'b1;
        #1 chk_reset_vals("arst");
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 30'h0, 1'b1);
        chk("arst_idle", 64'(ifc.out_valid), 64'(0));

        // Saturation on the 4-bit counter instance
        is2.in_valid  = 1'b1;
        is2.out_ready = 1'b0;
        @(negedge clk);
        is2.in_valid = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            int e;
            e = (k - 1 > 15) ? 15 : k - 1;
            chk("sat_cnt", 64'(is2.stall_cnt), 64'(e));
            @(negedge clk);
        end
        chk("sat_final", 64'(is2.stall_cnt), 64'(4'hF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
